mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, sitting between the EX/MEM and MEM/WB boundaries. It consumes the EX/MEM register outputs and drives a variable-latency data-memory handshake, stalling the pipeline while an access is outstanding. It resolves branch/jump redirection and contains the MEM/WB pipeline register feeding write-back.

## Interface
- WAIT_MAX, 15, maximum WAIT-state cycles before an access is abandoned (1..255)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- BranchMEM, MemReadMEM, MemWriteMEM, RegWriteMEM, MemtoRegMEM, JumpMEM  in  1 each  control from EX/MEM
- b_tgtMEM, alu_outMEM, rfile_rd2MEM, jump_addrMEM  in  32 each  branch target, ALU result/address, store data, jump target
- rfile_wnMEM  in  5  destination register
- ZeroMEM  in  1  ALU zero flag
- dm_req  out  1  memory request
- dm_we  out  1  write strobe (valid with dm_req)
- dm_addr, dm_wdata  out  32 each  address, store data
- dm_rdata  in  32  load data, valid with dm_ack
- dm_ack  in  1  access complete
- mem_stall  out  1  hold upstream; EX/MEM en_reg = ~mem_stall
- pc_src  out  1  redirect fetch
- pc_tgt  out  32  redirect target
- mem_err  out  1  one-cycle pulse on abandoned or rejected access
- RegWriteWB, MemtoRegWB  out  1 each  to WB
- rd_dataWB, alu_outWB  out  32 each  load data, ALU result
- rfile_wnWB  out  5  destination register

## Operation
- Access = MemReadMEM | MemWriteMEM; both set -> write (dm_we=1), RegWriteMEM still honoured.
- FSM states IDLE, WAIT; 8-bit wait counter.
- IDLE, no access: dm_req=0, mem_stall=0, MEM/WB loads instruction.
- IDLE, access: dm_req=1 combinationally; dm_ack=1 same cycle -> complete, no stall; else mem_stall=1, counter<=1, -> WAIT.
- WAIT: dm_req=1, dm_addr/dm_we/dm_wdata unchanged (EX/MEM held). dm_ack=1 -> complete, mem_stall=0, -> IDLE. No ack, counter==WAIT_MAX -> timeout: mem_err=1, mem_stall=0, dm_req drops next cycle, -> IDLE. Otherwise counter++, mem_stall=1.
- Complete: MEM/WB captures dm_rdata (rd_dataWB), alu_outMEM, rfile_wnMEM, RegWriteMEM, MemtoRegMEM.
- Timeout: MEM/WB captures instruction with RegWriteWB=0, rd_dataWB=0.
- Stalled cycle: MEM/WB loads bubble (RegWriteWB=0, MemtoRegWB=0, others 0).
- pc_src = JumpMEM | (BranchMEM & ZeroMEM); pc_tgt = JumpMEM ? jump_addrMEM : b_tgtMEM (jump priority); purely combinational, independent of FSM.
- dm_wdata = rfile_rd2MEM; dm_addr = alu_outMEM (subject to Configuration).

## Timing
- Reset: FSM IDLE, counter 0, all MEM/WB outputs 0; dm_req, mem_stall, mem_err 0 once reset sampled. Reset during WAIT abandons access without mem_err.
- Zero-wait access: 0 stall cycles; WB data 1 cycle after issue.
- Ack after N WAIT cycles (N>=1): mem_stall high N cycles; result in MEM/WB the clock edge ending ack cycle.
- dm_req high at most WAIT_MAX+1 consecutive cycles; ack in the final cycle wins over timeout.
- dm_ack outside a request ignored.
- Back-to-back accesses: new request may issue in the cycle after completion; dm_req may stay high across both.

## Configuration
- DM_ALIGN_CHECK_EN defined: access with alu_outMEM[1:0]!=0 not issued (dm_req=0), mem_err=1 for one cycle, no stall, MEM/WB receives it with RegWriteWB=0.
- Not defined: no check; dm_addr[1:0] forced to 2'b00, access proceeds.

## Test plan
- Load, alu_outMEM=0x100, dm_ack same cycle with dm_rdata=0xDEADBEEF, RegWrite=1, MemtoReg=1, wn=5 -> no stall; next cycle rd_dataWB=0xDEADBEEF, rfile_wnWB=5, RegWriteWB=1.
- Store to 0x40, data 0x1234, ack after 3 WAIT cycles -> dm_we=1, dm_wdata=0x1234 stable 4 cycles; mem_stall high 3 cycles; 3 WB bubbles.
- Load, no ack, WAIT_MAX=15 -> dm_req high 16 cycles, mem_err pulse in cycle 16, RegWriteWB=0, FSM IDLE.
- BranchMEM=1, ZeroMEM=1, b_tgt=0x80 -> pc_src=1, pc_tgt=0x80; add JumpMEM=1, jump_addr=0x200 -> pc_tgt=0x200; ZeroMEM=0, no jump -> pc_src=0.
- Reset asserted mid-WAIT (cycle 2) -> next cycle dm_req=0, mem_stall=0, all WB outputs 0, mem_err=0.
- DM_ALIGN_CHECK_EN, load at 0x102 -> dm_req=0, mem_err=1 one cycle, RegWriteWB=0; without macro -> dm_addr=0x100.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline with a variable-latency data-memory
// handshake, branch/jump redirect and the MEM/WB register. Optional macro DM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BranchMEM,
  input  logic              MemReadMEM,
  input  logic              MemWriteMEM,
  input  logic              RegWriteMEM,
  input  logic              MemtoRegMEM,
  input  logic              JumpMEM,
  input  logic [DATA_W-1:0] b_tgtMEM,
  input  logic [DATA_W-1:0] alu_outMEM,
  input  logic [DATA_W-1:0] rfile_rd2MEM,
  input  logic [DATA_W-1:0] jump_addrMEM,
  input  logic [4:0]        rfile_wnMEM,
  input  logic              ZeroMEM,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              mem_stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_tgt,
  output logic              mem_err,
  output logic              RegWriteWB,
  output logic              MemtoRegWB,
  output logic [DATA_W-1:0] rd_dataWB,
  output logic [DATA_W-1:0] alu_outWB,
  output logic [4:0]        rfile_wnWB
);

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic [1:0] {WB_BUBBLE, WB_PASS, WB_DONE, WB_DROP} wb_sel_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  wb_sel_t     wb_sel;
  logic        req, stall, err;
  logic        access, misalign;

  logic              regwrite_wb_q, regwrite_wb_d;
  logic              memtoreg_wb_q, memtoreg_wb_d;
  logic [DATA_W-1:0] rd_data_wb_q, rd_data_wb_d;
  logic [DATA_W-1:0] alu_out_wb_q, alu_out_wb_d;
  logic [4:0]        wn_wb_q, wn_wb_d;

  assign access = MemReadMEM | MemWriteMEM;

`ifdef DM_ALIGN_CHECK_EN
  assign misalign = access & (|alu_outMEM[1:0]);
  assign dm_addr  = alu_outMEM;
`else
  assign misalign = 1'b0;
  assign dm_addr  = alu_outMEM & ~DATA_W'(3);
`endif

  assign dm_we    = MemWriteMEM;
  assign dm_wdata = rfile_rd2MEM;

  // Redirect is resolved here regardless of the memory handshake; jump wins over branch.
  assign pc_src = JumpMEM | (BranchMEM & ZeroMEM);
  assign pc_tgt = JumpMEM ? jump_addrMEM : b_tgtMEM;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    err     = 1'b0;
    wb_sel  = WB_PASS;
    unique case (state_q)
      ST_IDLE: begin
        if (misalign) begin
          err    = 1'b1;
          wb_sel = WB_DROP;
        end else if (access) begin
          req = 1'b1;
          if (dm_ack) begin
            wb_sel = WB_DONE;
          end else begin
            stall   = 1'b1;
            cnt_d   = 8'd1;
            state_d = ST_WAIT;
            wb_sel  = WB_BUBBLE;
          end
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (dm_ack) begin
          wb_sel  = WB_DONE;
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == WAIT_LIM) begin
          // Abandon the access; the instruction still retires but writes nothing.
          err     = 1'b1;
          wb_sel  = WB_DROP;
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end else begin
          stall  = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          wb_sel = WB_BUBBLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // A cycle in which reset is sampled never requests, stalls or reports an error.
  assign dm_req    = req & ~reset;
  assign mem_stall = stall & ~reset;
  assign mem_err   = err & ~reset;

  always_comb begin
    regwrite_wb_d = 1'b0;
    memtoreg_wb_d = 1'b0;
    rd_data_wb_d  = '0;
    alu_out_wb_d  = '0;
    wn_wb_d       = '0;
    unique case (wb_sel)
      WB_PASS: begin
        regwrite_wb_d = RegWriteMEM;
        memtoreg_wb_d = MemtoRegMEM;
        alu_out_wb_d  = alu_outMEM;
        wn_wb_d       = rfile_wnMEM;
      end
      WB_DONE: begin
        regwrite_wb_d = RegWriteMEM;
        memtoreg_wb_d = MemtoRegMEM;
        rd_data_wb_d  = dm_rdata;
        alu_out_wb_d  = alu_outMEM;
        wn_wb_d       = rfile_wnMEM;
      end
      WB_DROP: begin
        memtoreg_wb_d = MemtoRegMEM;
        alu_out_wb_d  = alu_outMEM;
        wn_wb_d       = rfile_wnMEM;
      end
      default: begin
        regwrite_wb_d = 1'b0;
      end
    endcase
  end

  // MEM/WB boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      regwrite_wb_q <= 1'b0;
      memtoreg_wb_q <= 1'b0;
      rd_data_wb_q  <= '0;
      alu_out_wb_q  <= '0;
      wn_wb_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      regwrite_wb_q <= regwrite_wb_d;
      memtoreg_wb_q <= memtoreg_wb_d;
      rd_data_wb_q  <= rd_data_wb_d;
      alu_out_wb_q  <= alu_out_wb_d;
      wn_wb_q       <= wn_wb_d;
    end
  end

  assign RegWriteWB = regwrite_wb_q;
  assign MemtoRegWB = memtoreg_wb_q;
  assign rd_dataWB  = rd_data_wb_q;
  assign alu_outWB  = alu_out_wb_q;
  assign rfile_wnWB = wn_wb_q;

endmodule
